cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
Common-data-bus (broadcast) arbiter for the Tomasulo core. It collects completed results (label + data) from up to NUM_REQ producers: ALU reservation-station outputs, the load/store queue, and later units. It grants one result per cycle, round-robin, and drives the registered BCEN/BClabel/BCdata broadcast consumed by the register file, reservation stations and load/store queue. Each producer gets a one-entry holding slot so it can retire its result and move on before it wins the bus.

Parameters:
NUM_REQ, 4, number of producers (2..8)
DATA_W, 32, broadcast data width
LABEL_W, 4, reservation tag width; label 0 means "no tag / value ready" and is never broadcast

Ports:
clk  in  1  system clock, all state on rising edge
RST  in  1  reset: one clock; reset is synchronous and active-high
flush  in  1  squash all pending results (mispredict recovery)
req_valid  in  NUM_REQ  producer i offers a result
req_label  in  NUM_REQ*LABEL_W  packed labels, producer i at bits [i*LABEL_W +: LABEL_W]
req_data  in  NUM_REQ*DATA_W  packed data, same packing
req_ready  out  NUM_REQ  producer i's offer is accepted this cycle
BCEN  out  1  broadcast valid
BClabel  out  LABEL_W  broadcast tag
BCdata  out  DATA_W  broadcast value
BCsrc  out  3  index of the producer that owns the current broadcast
drop_err  out  1  one-cycle pulse: a label-0 offer was accepted and discarded

Behaviour:
- Reset (RST=1 at edge): all slots empty, rr_ptr=0, BCEN=0, BClabel=0, BCdata=0, BCsrc=0, drop_err=0. RST overrides flush and all inputs.
- Slot i holds {valid, label, data}.
- req_ready[i] = !slot_valid[i] | grant[i], combinational. A producer that alone holds the bus can therefore sustain 1 result/cycle.
- Accept: a producer is accepted when req_valid[i] & req_ready[i] at the edge. The slot loads label/data, except when label==0: the slot does not load and drop_err pulses the next cycle.
- Arbitration (combinational on slot_valid):
  - Winner is the first valid slot scanning from rr_ptr upward, with wrap-around.
  - grant is one-hot or zero.
  - On a grant, rr_ptr <= winner+1 mod NUM_REQ. With no grant, rr_ptr holds.
- Broadcast registers, updated every edge:
  - With a grant: BCEN<=1, BClabel/BCdata<=slot winner, BCsrc<=winner; the winner's slot is cleared unless refilled by the same-edge accept.
  - Without a grant: BCEN<=0; BClabel/BCdata/BCsrc hold their last values.
- Latency: accept at edge k -> slot valid after k -> earliest BCEN=1 in the cycle after edge k+1, i.e. 2 edges minimum. No bypass path.
- Simultaneous same-slot grant and accept: the old entry is broadcast and the new entry occupies the slot. Each producer has at most one entry, so order within a producer is preserved.
- flush=1 at edge:
  - All slots are cleared and BCEN<=0.
  - Accepts in that cycle are discarded; req_ready is still driven normally.
  - rr_ptr holds.
- Fairness bound: any valid slot is broadcast within NUM_REQ grant cycles.
- Labels are not checked for duplicates. Producers own tag uniqueness.

Decomposition:
- A shared package/header (alongside head.v) holds LABEL_W, DATA_W, the NO_LABEL=0 constant and the producer index assignments: ALU_RS=0, LSQ=1, spares 2..3.
- One sub-module, rr_pick: a pure combinational round-robin priority picker. Inputs: req vector and ptr. Outputs: one-hot grant and encoded index. The same picker is reusable for reservation-station issue selection.
- Slots, pointer and broadcast registers live in cdb_arbiter.

Test Plan:
- Reset: hold RST 2 cycles with all req_valid=1 -> BCEN=0, BClabel=0, BCdata=0, drop_err=0; nothing is broadcast in the first cycle after RST falls.
- Single producer: req 1 offers label 3, data 0xDEADBEEF at edge k -> BCEN=1, BClabel=3, BCdata=0xDEADBEEF, BCsrc=1 for exactly one cycle after edge k+1.
- All four offer labels 5,6,7,8 on the same edge, from rr_ptr=0 -> broadcasts on four consecutive cycles carry labels 5,6,7,8 and BCsrc=0,1,2,3. req_ready for producers 1..3 stays low until each is granted.
- Fairness: producer 0 offers continuously, producer 2 joins -> broadcasts alternate between BCsrc 0 and 2. Producer 0 streams at 1/cycle once producer 2 stops.
- Flush: three slots full, flush=1 for one edge -> BCEN=0 the next cycle, no stale labels ever broadcast, and the next new offer is broadcast with the 2-edge latency.
- Label 0: producer 3 offers label 0 -> accepted (req_ready=1), drop_err=1 for one cycle, BCEN stays 0.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared widths, constants and producer index assignments for the common data bus.
// Imported by the CDB arbiter and any unit that produces or consumes broadcasts.
package cdb_arbiter_pkg;

  localparam int CDB_NUM_REQ = 4;
  localparam int CDB_LABEL_W = 4;
  localparam int CDB_DATA_W  = 32;

  // Tag 0 marks an operand that is already ready; it must never reach the bus.
  localparam logic [CDB_LABEL_W-1:0] NO_LABEL = '0;

  typedef enum logic [2:0] {
    PROD_ALU_RS = 3'd0,
    PROD_LSQ    = 3'd1,
    PROD_SPARE2 = 3'd2,
    PROD_SPARE3 = 3'd3
  } prod_e;

  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i, with wrap.
// Reusable for reservation-station issue selection.
module rr_pick #(
  parameter int N     = 4,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N-1:0]     grant_o,
  output logic [PTR_W-1:0] idx_o,
  output logic             valid_o
);

  localparam int SW = PTR_W + 1;

  logic [N-1:0]  rotated;
  logic [SW-1:0] sum;

  // Rotate so the pointer lands on bit 0; scanning downward leaves the lowest hit.
  always_comb begin
    rotated = N'({req_i, req_i} >> ptr_i);
    valid_o = 1'b0;
    sum     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rotated[k]) begin
        valid_o = 1'b1;
        sum     = {1'b0, ptr_i} + SW'(k);
      end
    end
    if (sum >= SW'(N)) begin
      sum = sum - SW'(N);
    end
    idx_o   = sum[PTR_W-1:0];
    grant_o = valid_o ? (N'(1) << idx_o) : '0;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: one holding slot per producer, round-robin grant,
// registered BCEN/BClabel/BCdata/BCsrc broadcast.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = CDB_NUM_REQ,
  parameter int DATA_W  = CDB_DATA_W,
  parameter int LABEL_W = CDB_LABEL_W
) (
  input  logic                       clk,
  input  logic                       RST,
  input  logic                       flush,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*LABEL_W-1:0] req_label,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       BCEN,
  output logic [LABEL_W-1:0]         BClabel,
  output logic [DATA_W-1:0]          BCdata,
  output logic [2:0]                 BCsrc,
  output logic                       drop_err
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] slot_valid_q, slot_valid_d;
  logic [LABEL_W-1:0] slot_label_q [NUM_REQ];
  logic [LABEL_W-1:0] slot_label_d [NUM_REQ];
  logic [DATA_W-1:0]  slot_data_q  [NUM_REQ];
  logic [DATA_W-1:0]  slot_data_d  [NUM_REQ];
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;

  logic               bcen_q, bcen_d;
  logic [LABEL_W-1:0] bclabel_q, bclabel_d;
  logic [DATA_W-1:0]  bcdata_q, bcdata_d;
  logic [2:0]         bcsrc_q, bcsrc_d;
  logic               drop_q, drop_d;

  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] accept;
  logic [PTR_W-1:0]   win_idx;
  logic               grant_any;

  rr_pick #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req_i   (slot_valid_q),
    .ptr_i   (rr_ptr_q),
    .grant_o (grant),
    .idx_o   (win_idx),
    .valid_o (grant_any)
  );

  // A slot being granted this edge can take a new entry at the same edge.
  assign req_ready = ~slot_valid_q | grant;
  assign accept    = req_valid & req_ready;

  always_comb begin
    slot_valid_d = slot_valid_q;
    slot_label_d = slot_label_q;
    slot_data_d  = slot_data_q;
    rr_ptr_d     = rr_ptr_q;
    bcen_d       = 1'b0;
    bclabel_d    = bclabel_q;
    bcdata_d     = bcdata_q;
    bcsrc_d      = bcsrc_q;
    drop_d       = 1'b0;

    if (flush) begin
      slot_valid_d = '0;
    end else begin
      if (grant_any) begin
        bcen_d    = 1'b1;
        bclabel_d = slot_label_q[win_idx];
        bcdata_d  = slot_data_q[win_idx];
        bcsrc_d   = 3'(win_idx);
        rr_ptr_d  = PTR_W'(wrap_inc(32'(win_idx), NUM_REQ));
      end
      // Clearing the winner before loading lets a same-edge accept refill its slot.
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant[i]) begin
          slot_valid_d[i] = 1'b0;
        end
        if (accept[i]) begin
          if (req_label[i*LABEL_W +: LABEL_W] == LABEL_W'(NO_LABEL)) begin
            drop_d = 1'b1;
          end else begin
            slot_valid_d[i] = 1'b1;
            slot_label_d[i] = req_label[i*LABEL_W +: LABEL_W];
            slot_data_d[i]  = req_data[i*DATA_W +: DATA_W];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      slot_valid_q <= '0;
      slot_label_q <= '{default: '0};
      slot_data_q  <= '{default: '0};
      rr_ptr_q     <= '0;
      bcen_q       <= 1'b0;
      bclabel_q    <= '0;
      bcdata_q     <= '0;
      bcsrc_q      <= '0;
      drop_q       <= 1'b0;
    end else begin
      slot_valid_q <= slot_valid_d;
      slot_label_q <= slot_label_d;
      slot_data_q  <= slot_data_d;
      rr_ptr_q     <= rr_ptr_d;
      bcen_q       <= bcen_d;
      bclabel_q    <= bclabel_d;
      bcdata_q     <= bcdata_d;
      bcsrc_q      <= bcsrc_d;
      drop_q       <= drop_d;
    end
  end

  assign BCEN     = bcen_q;
  assign BClabel  = bclabel_q;
  assign BCdata   = bcdata_q;
  assign BCsrc    = bcsrc_q;
  assign drop_err = drop_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a slot-level reference model.
module tb_cdb_arbiter;

  localparam int N  = 4;
  localparam int LW = 4;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              RST;
  logic              flush;
  logic [N-1:0]      req_valid;
  logic [N*LW-1:0]   req_label;
  logic [N*DW-1:0]   req_data;
  logic [N-1:0]      req_ready;
  logic              BCEN;
  logic [LW-1:0]     BClabel;
  logic [DW-1:0]     BCdata;
  logic [2:0]        BCsrc;
  logic              drop_err;

  cdb_arbiter #(.NUM_REQ(N), .DATA_W(DW), .LABEL_W(LW)) dut (
    .clk       (clk),
    .RST       (RST),
    .flush     (flush),
    .req_valid (req_valid),
    .req_label (req_label),
    .req_data  (req_data),
    .req_ready (req_ready),
    .BCEN      (BCEN),
    .BClabel   (BClabel),
    .BCdata    (BCdata),
    .BCsrc     (BCsrc),
    .drop_err  (drop_err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  bit          dRst;
  bit          dFlush;
  bit [N-1:0]  dValid;
  bit [LW-1:0] dLabel [N];
  bit [DW-1:0] dData  [N];

  // Reference model: pending entry per producer, pointer as a plain integer.
  bit          mInit = 1'b0;
  bit          mV [N];
  bit [LW-1:0] mL [N];
  bit [DW-1:0] mD [N];
  int          mPtr;
  bit          mBcen;
  bit [LW-1:0] mLabel;
  bit [DW-1:0] mData;
  int          mSrc;
  bit          mDrop;

  logic [N-1:0] obsReady;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int modelWinner();
    for (int k = 0; k < N; k++) begin
      int j = (mPtr + k) % N;
      if (mV[j]) return j;
    end
    return -1;
  endfunction

  function automatic bit [N-1:0] modelReady();
    bit [N-1:0] r;
    int w = modelWinner();
    for (int i = 0; i < N; i++) r[i] = !mV[i] || (i == w);
    return r;
  endfunction

  function automatic void modelStep();
    int w;
    bit [N-1:0] rdy;
    if (dRst) begin
      for (int i = 0; i < N; i++) mV[i] = 1'b0;
      mPtr = 0; mBcen = 0; mLabel = '0; mData = '0; mSrc = 0; mDrop = 0;
      mInit = 1'b1;
      return;
    end
    w   = modelWinner();
    rdy = modelReady();
    mDrop = 1'b0;
    if (dFlush) begin
      for (int i = 0; i < N; i++) mV[i] = 1'b0;
      mBcen = 1'b0;
      return;
    end
    if (w >= 0) begin
      mBcen = 1'b1; mLabel = mL[w]; mData = mD[w]; mSrc = w;
      mV[w] = 1'b0;
      mPtr  = (w + 1) % N;
    end else begin
      mBcen = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      if (dValid[i] && rdy[i]) begin
        if (dLabel[i] == 0) mDrop = 1'b1;
        else begin
          mV[i] = 1'b1; mL[i] = dLabel[i]; mD[i] = dData[i];
        end
      end
    end
  endfunction

  task automatic checkOutput();
    if (mInit) begin
      check("BCEN", BCEN, mBcen);
      check("BClabel", BClabel, mLabel);
      check("BCdata", BCdata, mData);
      check("BCsrc", BCsrc, mSrc);
      check("drop_err", drop_err, mDrop);
    end
  endtask

  task automatic applyStimulus();
    RST       = dRst;
    flush     = dFlush;
    req_valid = dValid;
    for (int i = 0; i < N; i++) begin
      req_label[i*LW +: LW] = dLabel[i];
      req_data[i*DW +: DW]  = dData[i];
    end
    #1;
    obsReady = req_ready;
    if (mInit) check("req_ready", req_ready, modelReady());
    @(posedge clk);
    modelStep();
    #1;
    checkOutput();
  endtask

  task automatic idle();
    dRst = 0; dFlush = 0; dValid = '0;
  endtask

  task automatic offer(input int p, input bit [LW-1:0] lbl, input bit [DW-1:0] dat);
    dValid[p] = 1'b1; dLabel[p] = lbl; dData[p] = dat;
  endtask

  int prevSrc;

  initial begin
    idle();
    for (int i = 0; i < N; i++) begin dLabel[i] = LW'(i + 1); dData[i] = 32'h100 + i; end

    // Reset held two cycles with everyone offering
    dRst = 1; dValid = '1;
    applyStimulus();
    applyStimulus();
    check("rst_BCEN", BCEN, 0);
    check("rst_BClabel", BClabel, 0);
    check("rst_BCdata", BCdata, 0);
    check("rst_drop", drop_err, 0);
    idle();
    applyStimulus();
    check("post_rst_BCEN", BCEN, 0);

    // All four producers on one edge from rr_ptr=0
    offer(0, 5, 32'hA5); offer(1, 6, 32'hA6); offer(2, 7, 32'hA7); offer(3, 8, 32'hA8);
    applyStimulus();
    check("four_no_bypass", BCEN, 0);
    idle();
    for (int k = 0; k < 4; k++) begin
      applyStimulus();
      if (k == 0) check("four_ready", obsReady, 4'b0001);
      check("four_BCEN", BCEN, 1);
      check("four_label", BClabel, 5 + k);
      check("four_src", BCsrc, k);
    end
    applyStimulus();
    check("four_done", BCEN, 0);

    // Single producer, two-edge latency, one broadcast cycle
    offer(1, 3, 32'hDEADBEEF);
    applyStimulus();
    check("single_lat", BCEN, 0);
    idle();
    applyStimulus();
    check("single_BCEN", BCEN, 1);
    check("single_label", BClabel, 3);
    check("single_data", BCdata, 32'hDEADBEEF);
    check("single_src", BCsrc, 1);
    applyStimulus();
    check("single_once", BCEN, 0);

    // Label 0 is accepted and dropped
    offer(3, 0, 32'h55);
    applyStimulus();
    check("lbl0_ready", obsReady[3], 1);
    check("lbl0_drop", drop_err, 1);
    check("lbl0_nobc", BCEN, 0);
    idle();
    applyStimulus();
    check("lbl0_pulse", drop_err, 0);
    check("lbl0_nobc2", BCEN, 0);

    // Fairness: producer 0 streams, producer 2 joins, then leaves
    for (int c = 0; c < 10; c++) begin
      offer(0, 9, DW'(32'h900 + c));
      offer(2, 10, DW'(32'hA00 + c));
      applyStimulus();
      if (c >= 3) check("fair_alt", (BCsrc != 3'(prevSrc)) && BCEN, 1);
      prevSrc = BCsrc;
    end
    dValid[2] = 1'b0;
    for (int c = 0; c < 6; c++) begin
      offer(0, 9, DW'(32'hB00 + c));
      applyStimulus();
      if (c >= 2) begin
        check("stream_BCEN", BCEN, 1);
        check("stream_src", BCsrc, 0);
      end
    end
    idle();
    repeat (4) applyStimulus();

    // Flush with three slots full
    offer(0, 12, 32'hC0); offer(1, 13, 32'hC1); offer(2, 14, 32'hC2);
    applyStimulus();
    idle(); dFlush = 1;
    applyStimulus();
    check("flush_BCEN", BCEN, 0);
    idle();
    for (int c = 0; c < 3; c++) begin
      applyStimulus();
      check("flush_nostale", BCEN, 0);
    end
    offer(3, 11, 32'h1234);
    applyStimulus();
    check("flush_lat", BCEN, 0);
    idle();
    applyStimulus();
    check("flush_new_BCEN", BCEN, 1);
    check("flush_new_label", BClabel, 11);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      dRst   = ($urandom % 300) == 0;
      dFlush = ($urandom % 30) == 0;
      for (int i = 0; i < N; i++) begin
        dValid[i] = ($urandom % 100) < 30 + 15 * i;
        dLabel[i] = (($urandom % 12) == 0) ? LW'(0) : LW'($urandom_range(1, 15));
        dData[i]  = $urandom;
      end
      applyStimulus();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
